// File: rtl/sub2stage_pipe.sv
// rtl/sub2stage_pipe.sv - two-stage pipelined subtractor with valid/ready handshake
//
// Purpose: computes in_1 - in_2 as in_1 + ~in_2 + 1. Stage 1 subtracts the low
// half and registers its carry. Stage 2 finishes the high half using that carry,
// then derives borrow and signed overflow.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     operand pair present on in_1/in_2
//   in_ready     pair accepted this cycle (combinational from out_ready only)
//   in_1, in_2   minuend, subtrahend (WIDTH bits)
//   out_valid    result on out_* is valid
//   out_ready    downstream accepts the result this cycle
//   out_diff     (in_1 - in_2) mod 2^WIDTH
//   out_borrow   in_1 < in_2, unsigned
//   out_overflow two's-complement overflow of the signed difference
module sub2stage_pipe #(
  parameter  int WIDTH = 32,
  localparam int LO    = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_overflow
);

  localparam int HI = WIDTH - LO;

  // Stage 1 state
  logic          s1_valid_q;
  logic [LO-1:0] s1_lo_q,  s1_lo_d;
  logic          s1_c_q,   s1_c_d;
  logic [HI-1:0] s1_hi1_q;
  logic [HI-1:0] s1_hi2_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_diff_q,  s2_diff_d;
  logic             s2_borrow_q, s2_borrow_d;
  logic             s2_ovf_q,    s2_ovf_d;

  logic s2_free;
  logic s1_adv;
  logic in_fire;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;

  // Low half: the "+1" of two's-complement negation enters here as carry-in.
  always_comb begin
    logic [LO:0] lo_sum;
    lo_sum  = {1'b0, in_1[LO-1:0]} + {1'b0, ~in_2[LO-1:0]} + {{LO{1'b0}}, 1'b1};
    s1_lo_d = lo_sum[LO-1:0];
    s1_c_d  = lo_sum[LO];
  end

  // High half: carry-in is the low-half carry; a missing carry-out means borrow.
  always_comb begin
    logic [HI:0] hi_sum;
    hi_sum      = {1'b0, s1_hi1_q} + {1'b0, ~s1_hi2_q} + {{HI{1'b0}}, s1_c_q};
    s2_diff_d   = {hi_sum[HI-1:0], s1_lo_q};
    s2_borrow_d = ~hi_sum[HI];
    // Overflow only when operand signs differ and the result sign leaves the minuend's.
    s2_ovf_d    = (s1_hi1_q[HI-1] != s1_hi2_q[HI-1]) &&
                  (hi_sum[HI-1] != s1_hi1_q[HI-1]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_hi1_q   <= '0;
      s1_hi2_q   <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_lo_q    <= s1_lo_d;
        s1_c_q     <= s1_c_d;
        s1_hi1_q   <= in_1[WIDTH-1:LO];
        s1_hi2_q   <= in_2[WIDTH-1:LO];
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // When draining (s2 consumed, nothing in s1) only the flag clears; data holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q  <= 1'b0;
      s2_diff_q   <= '0;
      s2_borrow_q <= 1'b0;
      s2_ovf_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid_q  <= 1'b1;
        s2_diff_q   <= s2_diff_d;
        s2_borrow_q <= s2_borrow_d;
        s2_ovf_q    <= s2_ovf_d;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_diff     = s2_diff_q;
  assign out_borrow   = s2_borrow_q;
  assign out_overflow = s2_ovf_q;

endmodule
